// File: rtl/scan_frame_capture_if.sv
// scan_frame_capture_if
//   Groups the scanner-facing inputs, the display-buffer read port and the
//   frame status outputs of scan_frame_capture.
//
//   Signals
//     col_sel     [3:0]  column index currently driven by the display scanner
//     row_L       [4:0]  active-low row pattern for the selected column
//     rd_col      [3:0]  display-buffer read column
//     rd_data     [4:0]  active-high pixels of column rd_col
//     frame_valid        one-cycle pulse per completed frame
//     frame_count [7:0]  completed frame counter (wraps)
//     seq_err            sticky out-of-order column flag
//
//   Modports
//     master : scanner / reader side (drives col_sel, row_L, rd_col)
//     slave  : capture block side
interface scan_frame_capture_if;
  logic [3:0] col_sel;
  logic [4:0] row_L;
  logic [3:0] rd_col;
  logic [4:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_count;
  logic       seq_err;

  modport master (
    output col_sel,
    output row_L,
    output rd_col,
    input  rd_data,
    input  frame_valid,
    input  frame_count,
    input  seq_err
  );

  modport slave (
    input  col_sel,
    input  row_L,
    input  rd_col,
    output rd_data,
    output frame_valid,
    output frame_count,
    output seq_err
  );
endinterface

// File: rtl/scan_frame_capture.sv
// scan_frame_capture
//   Samples a multiplexed LED-matrix scan (column index plus active-low row
//   pattern, both asynchronous), waits for each column/row pair to settle,
//   commits it into a shadow frame and, once every column has been seen,
//   transfers the shadow frame into a readable display buffer.
//
//   Parameters
//     NUM_COLS       number of scanned columns (2..16)
//     STABLE_CYCLES  synchronized cycles a pair must hold before commit (2..15)
//
//   Ports
//     clock  single clock, rising edge
//     reset  asynchronous, active-high
//     bus    scan_frame_capture_if.slave (scan inputs, read port, status)
//
//   FSM
//     state  | meaning
//     SETTLE | waiting for the current {col,row} pair to be stable
//     HELD   | current dwell already committed; wait for the next change
module scan_frame_capture #(
  parameter int NUM_COLS      = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  scan_frame_capture_if.slave  bus
);

  localparam logic [3:0]  LAST_COL = 4'(NUM_COLS - 1);
  localparam logic [3:0]  CNT_MAX  = 4'(STABLE_CYCLES - 1);
  localparam logic [15:0] COL_MASK = 16'((32'd1 << NUM_COLS) - 32'd1);
  localparam logic [4:0]  ROW_IDLE = 5'b11111;

  typedef enum logic {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;

  // two-flop synchronizers
  logic [3:0] col_s1;
  logic [3:0] sc;
  logic [4:0] row_s1;
  logic [4:0] sr;

  // previous synchronized pair and stability counter
  logic [8:0] prev_pair;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       changed;
  logic       commit;

  // frame assembly
  logic [4:0]  shadow [0:15];
  logic [4:0]  disp   [0:15];
  logic [15:0] seen;
  logic [15:0] seen_next;
  logic [3:0]  last_col;
  logic        last_valid;
  logic [3:0]  exp_col;
  logic        col_valid;
  logic        valid_commit;
  logic        order_err;
  logic        frame_done;

  logic        frame_valid_q;
  logic [7:0]  frame_count_q;
  logic        seq_err_q;

  // ------------------------------------------------------------------
  // Synchronizers and stability counter
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_s1    <= 4'd0;
      sc        <= 4'd0;
      row_s1    <= ROW_IDLE;
      sr        <= ROW_IDLE;
      prev_pair <= {4'd0, ROW_IDLE};
      cnt       <= 4'd0;
    end else begin
      col_s1    <= bus.col_sel;
      sc        <= col_s1;
      row_s1    <= bus.row_L;
      sr        <= row_s1;
      prev_pair <= {sc, sr};
      cnt       <= cnt_next;
    end
  end

  // The commit decision uses the counter value being written this edge, so
  // the commit lands on the same edge the counter reaches CNT_MAX.
  always_comb begin
    changed  = ({sc, sr} != prev_pair);
    cnt_next = cnt;
    if (changed) begin
      cnt_next = 4'd0;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + 4'd1;
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SETTLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      SETTLE: begin
        if (cnt_next == CNT_MAX) begin
          commit     = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (changed) begin
          state_next = SETTLE;
        end
      end
      default: begin
        state_next = SETTLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Commit qualification
  // ------------------------------------------------------------------
  always_comb begin
    col_valid    = (sc <= LAST_COL);
    valid_commit = commit && col_valid;
    seen_next    = seen | (16'd1 << sc);
    frame_done   = valid_commit && ((seen_next & COL_MASK) == COL_MASK);
    exp_col      = (last_col == LAST_COL) ? 4'd0 : (last_col + 4'd1);
    // The first valid commit after reset has no predecessor to compare with.
    order_err    = valid_commit && last_valid && (sc != exp_col);
  end

  // ------------------------------------------------------------------
  // Shadow frame, display buffer and status
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= 5'd0;
        disp[i]   <= 5'd0;
      end
      seen          <= 16'd0;
      last_col      <= 4'd0;
      last_valid    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_count_q <= 8'd0;
      seq_err_q     <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (valid_commit) begin
        shadow[sc] <= ~sr;
        last_col   <= sc;
        last_valid <= 1'b1;
        if (order_err) begin
          seq_err_q <= 1'b1;
        end
        if (frame_done) begin
          // The committing column is not yet in shadow, so merge it here.
          for (int i = 0; i < 16; i++) begin
            disp[i] <= (4'(i) == sc) ? ~sr : shadow[i];
          end
          seen          <= 16'd0;
          frame_count_q <= frame_count_q + 8'd1;
          frame_valid_q <= 1'b1;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

  // Read port is combinational from the registered buffer, so a same-cycle
  // load is seen only after the edge.
  assign bus.rd_data     = (bus.rd_col <= LAST_COL) ? disp[bus.rd_col] : 5'd0;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_count = frame_count_q;
  assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_scan_frame_capture.sv
// tb_scan_frame_capture
//   Directed table of scan dwells with hand-computed frame count, pulse count,
//   seq_err and display-buffer contents, plus hand-written sequences for
//   commit latency and frame counter wrap. NUM_COLS=4, STABLE_CYCLES=4.
module tb_scan_frame_capture;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  scan_frame_capture_if bus ();

  scan_frame_capture #(
    .NUM_COLS      (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  col;
    logic [4:0]  row;
    int          cyc;
    int          fc;
    int          pulses;
    logic        se;
    logic        chk_rd;
    logic [19:0] rd;     // {col3, col2, col1, col0}
  } vec_t;

  vec_t tbl[$];

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int doubles = 0;
  int base = 0;
  logic fv_prev = 1'b0;

  always @(negedge clock) begin
    if (bus.frame_valid) begin
      pulses++;
      if (fv_prev) doubles++;
    end
    fv_prev = bus.frame_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] col,
                              input logic [4:0] row, input int cyc,
                              input int fc, input int p, input logic se,
                              input logic chk, input logic [19:0] rd);
    vec_t v;
    v.rst = rst; v.col = col; v.row = row; v.cyc = cyc;
    v.fc = fc; v.pulses = p; v.se = se; v.chk_rd = chk; v.rd = rd;
    tbl.push_back(v);
  endfunction

  task automatic check_rd(input logic [19:0] exp);
    logic [19:0] e;
    e = exp;
    for (int c = 0; c < 4; c++) begin
      bus.rd_col = 4'(c);
      #1;
      check($sformatf("rd_data[%0d]", c), int'(bus.rd_data), int'(e[c*5 +: 5]));
    end
    bus.rd_col = 4'd7;
    #1;
    check("rd_data[7]", int'(bus.rd_data), 0);
  endtask

  task automatic do_reset(input logic [3:0] col, input logic [4:0] row);
    @(negedge clock);
    bus.col_sel = col;
    bus.row_L   = row;
    reset = 1'b1;
    base = pulses;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst frame_count", int'(bus.frame_count), 0);
    check("rst seq_err", int'(bus.seq_err), 0);
    check("rst frame_valid", int'(bus.frame_valid), 0);
    check_rd(20'd0);
  endtask

  // Dwell of exactly cyc cycles; returns 1 ns after the last negedge.
  task automatic hold(input logic [3:0] col, input logic [4:0] row, input int cyc);
    @(negedge clock);
    bus.col_sel = col;
    bus.row_L   = row;
    repeat (cyc - 1) @(negedge clock);
    #1;
  endtask

  initial begin
    int k;
    bus.col_sel = 4'd0;
    bus.row_L   = 5'b11110;
    bus.rd_col  = 4'd0;

    // basic frame
    add(1, 0, 5'b11110, 10, 0, 0, 0, 0, 20'd0);
    add(0, 1, 5'b11101, 10, 0, 0, 0, 0, 20'd0);
    add(0, 2, 5'b11011, 10, 0, 0, 0, 0, 20'd0);
    add(0, 3, 5'b10111, 10, 1, 1, 0, 1, {5'b01000, 5'b00100, 5'b00010, 5'b00001});
    // out-of-range column between valid ones
    add(0, 0, 5'b01111, 10, 1, 1, 0, 0, 20'd0);
    add(0, 7, 5'b00000, 20, 1, 1, 0, 0, 20'd0);
    add(0, 1, 5'b10111, 10, 1, 1, 0, 0, 20'd0);
    add(0, 2, 5'b11011, 10, 1, 1, 0, 0, 20'd0);
    add(0, 3, 5'b11101, 10, 2, 2, 0, 1, {5'b00010, 5'b00100, 5'b01000, 5'b10000});
    // order 0,2,1,3
    add(0, 0, 5'b11100, 10, 2, 2, 0, 0, 20'd0);
    add(0, 2, 5'b11000, 10, 2, 2, 1, 0, 20'd0);
    add(0, 1, 5'b10000, 10, 2, 2, 1, 0, 20'd0);
    add(0, 3, 5'b00000, 10, 3, 3, 1, 1, {5'b11111, 5'b00111, 5'b01111, 5'b00011});
    // correct frame, seq_err stays set
    add(0, 0, 5'b11110, 10, 3, 3, 1, 0, 20'd0);
    add(0, 1, 5'b11101, 10, 3, 3, 1, 0, 20'd0);
    add(0, 2, 5'b11011, 10, 3, 3, 1, 0, 20'd0);
    add(0, 3, 5'b10111, 10, 4, 4, 1, 0, 20'd0);
    // glitching col 2 must not commit: col 3 then does not finish the frame
    add(0, 0, 5'b01111, 10, 4, 4, 1, 0, 20'd0);
    add(0, 1, 5'b10111, 10, 4, 4, 1, 0, 20'd0);
    add(0, 2, 5'b00000, 2, 4, 4, 1, 0, 20'd0);
    add(0, 2, 5'b11111, 2, 4, 4, 1, 0, 20'd0);
    add(0, 2, 5'b00000, 2, 4, 4, 1, 0, 20'd0);
    add(0, 2, 5'b11111, 2, 4, 4, 1, 0, 20'd0);
    add(0, 2, 5'b00000, 2, 4, 4, 1, 0, 20'd0);
    add(0, 3, 5'b11101, 10, 4, 4, 1, 0, 20'd0);
    add(0, 2, 5'b11011, 10, 5, 5, 1, 1, {5'b00010, 5'b00100, 5'b01000, 5'b10000});
    // partial frame discarded by reset
    add(0, 0, 5'b11110, 10, 5, 5, 1, 0, 20'd0);
    add(0, 1, 5'b11101, 10, 5, 5, 1, 0, 20'd0);
    add(0, 2, 5'b11011, 10, 5, 5, 1, 0, 20'd0);
    add(1, 0, 5'b01111, 10, 0, 0, 0, 0, 20'd0);
    add(0, 1, 5'b10111, 10, 0, 0, 0, 0, 20'd0);
    add(0, 2, 5'b10011, 10, 0, 0, 0, 0, 20'd0);
    add(0, 3, 5'b11101, 10, 1, 1, 0, 1, {5'b00010, 5'b01100, 5'b01000, 5'b10000});
    // reset value {0,11111} commits column 0 as all-off
    add(1, 0, 5'b11111, 10, 0, 0, 0, 0, 20'd0);
    add(0, 1, 5'b11110, 10, 0, 0, 0, 0, 20'd0);
    add(0, 2, 5'b11101, 10, 0, 0, 0, 0, 20'd0);
    add(0, 3, 5'b11011, 10, 1, 1, 0, 1, {5'b00100, 5'b00010, 5'b00001, 5'b00000});

    repeat (3) @(negedge clock);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(tbl[i].col, tbl[i].row);
      hold(tbl[i].col, tbl[i].row, tbl[i].cyc);
      check($sformatf("v%0d frame_count", i), int'(bus.frame_count), tbl[i].fc);
      check($sformatf("v%0d pulses", i), pulses - base, tbl[i].pulses);
      check($sformatf("v%0d seq_err", i), int'(bus.seq_err), int'(tbl[i].se));
      if (tbl[i].chk_rd) check_rd(tbl[i].rd);
    end

    // commit latency: change to last column, frame_valid follows the commit edge
    do_reset(4'd0, 5'b11110);
    hold(4'd0, 5'b11110, 10);
    hold(4'd1, 5'b11101, 10);
    hold(4'd2, 5'b11011, 10);
    @(negedge clock);
    bus.col_sel = 4'd3;
    bus.row_L   = 5'b10111;
    k = 0;
    while (k < 20) begin
      @(negedge clock);
      #1;
      k++;
      if (bus.frame_valid) break;
    end
    check("latency negedges", k, 6);
    @(negedge clock);
    #1;
    check("frame_valid width", int'(bus.frame_valid), 0);

    // 256 frames wrap the counter
    do_reset(4'd0, 5'b11110);
    for (int f = 0; f < 256; f++) begin
      for (int c = 0; c < 4; c++) begin
        logic [4:0] r;
        r = ~(5'(1) << c);
        hold(4'(c), r, 7);
      end
    end
    check("wrap frame_count", int'(bus.frame_count), 0);
    check("wrap pulses", pulses - base, 256);
    check_rd({5'b01000, 5'b00100, 5'b00010, 5'b00001});
    check("double pulses", doubles, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
